// File: rtl/order_out_fifo.sv
// First-word-fall-through capture FIFO for the strategy core's seven-word order bus.
// Records are stored whole; the head record is decoded from registered state, and drops are counted when the FIFO is full.
module order_out_fifo #(
  parameter int REG_WIDTH      = 32,
  parameter int BUFFER_SIZE    = 32,
  parameter int ALMOST_FULL    = 30,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_valid,
  input  logic [REG_WIDTH-1:0]             i_reg_1,
  input  logic [REG_WIDTH-1:0]             i_reg_2,
  input  logic [REG_WIDTH-1:0]             i_reg_3,
  input  logic [REG_WIDTH-1:0]             i_reg_4,
  input  logic [REG_WIDTH-1:0]             i_reg_5,
  input  logic [REG_WIDTH-1:0]             i_reg_6,
  input  logic [REG_WIDTH-1:0]             i_reg_7,
  input  logic                             i_pop,
  input  logic                             i_clear_overflow,
  output logic [REG_WIDTH-1:0]             o_reg_1,
  output logic [REG_WIDTH-1:0]             o_reg_2,
  output logic [REG_WIDTH-1:0]             o_reg_3,
  output logic [REG_WIDTH-1:0]             o_reg_4,
  output logic [REG_WIDTH-1:0]             o_reg_5,
  output logic [REG_WIDTH-1:0]             o_reg_6,
  output logic [REG_WIDTH-1:0]             o_reg_7,
  output logic                             o_rec_valid,
  output logic [$clog2(BUFFER_SIZE):0]     o_count,
  output logic                             o_full,
  output logic                             o_almost_full,
  output logic                             o_overflow,
  output logic [DROP_CNT_WIDTH-1:0]        o_drop_count
);

  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = PW + 1;
  localparam int RW = 7 * REG_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

  logic [RW-1:0]             r_mem [BUFFER_SIZE];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic                      r_overflow;
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [RW-1:0] w_in_rec;
  logic [RW-1:0] w_head;
  logic [REG_WIDTH-1:0] w_words [7];

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_pop    = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push   = i_valid && (!w_full || w_pop);
  assign w_drop   = i_valid && w_full && !w_pop;
  assign w_in_rec = {i_reg_7, i_reg_6, i_reg_5, i_reg_4, i_reg_3, i_reg_2, i_reg_1};

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_rec;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear restarts the statistics at one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      if (i_clear_overflow)
        r_drop_count <= DROP_CNT_WIDTH'(1);
      else if (r_drop_count != DROP_MAX)
        r_drop_count <= r_drop_count + DROP_CNT_WIDTH'(1);
    end else if (i_clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  for (genvar gi = 0; gi < 7; gi++) begin : g_words
    assign w_words[gi] = w_head[gi*REG_WIDTH +: REG_WIDTH];
  end

  assign o_reg_1       = w_words[0];
  assign o_reg_2       = w_words[1];
  assign o_reg_3       = w_words[2];
  assign o_reg_4       = w_words[3];
  assign o_reg_5       = w_words[4];
  assign o_reg_6       = w_words[5];
  assign o_reg_7       = w_words[6];
  assign o_rec_valid   = !w_empty;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_almost_full = (r_count >= AF_CNT);
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_order_out_fifo.sv
// Randomised and directed bench for order_out_fifo, compared every cycle against a queue model of the FIFO.
module tb_order_out_fifo;
  localparam int RW = 32;

  logic clk;
  logic rst_n;
  logic i_valid, i_pop, i_clr;
  logic [RW-1:0] i_r [7];
  logic [RW-1:0] o_r1, o_r2, o_r3, o_r4, o_r5, o_r6, o_r7;
  logic o_rec_valid, o_full, o_almost_full, o_overflow;
  logic [5:0] o_count;
  logic [15:0] o_drop_count;

  order_out_fifo #(.REG_WIDTH(32), .BUFFER_SIZE(32), .ALMOST_FULL(30), .DROP_CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid),
    .i_reg_1(i_r[0]), .i_reg_2(i_r[1]), .i_reg_3(i_r[2]), .i_reg_4(i_r[3]),
    .i_reg_5(i_r[4]), .i_reg_6(i_r[5]), .i_reg_7(i_r[6]),
    .i_pop(i_pop), .i_clear_overflow(i_clr),
    .o_reg_1(o_r1), .o_reg_2(o_r2), .o_reg_3(o_r3), .o_reg_4(o_r4),
    .o_reg_5(o_r5), .o_reg_6(o_r6), .o_reg_7(o_r7),
    .o_rec_valid(o_rec_valid), .o_count(o_count), .o_full(o_full),
    .o_almost_full(o_almost_full), .o_overflow(o_overflow), .o_drop_count(o_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of packed records plus overflow statistics.
  logic [223:0] m_q [$];
  logic         m_ovf = 1'b0;
  logic [15:0]  m_drop = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = '0;
      end else begin
        bit was_full, popped, dropped;
        was_full = (m_q.size() == 32);
        popped   = i_pop && (m_q.size() > 0);
        dropped  = i_valid && was_full && !popped;
        if (popped) void'(m_q.pop_front());
        if (i_valid && !dropped)
          m_q.push_back({i_r[6], i_r[5], i_r[4], i_r[3], i_r[2], i_r[1], i_r[0]});
        if (dropped) begin
          m_ovf = 1'b1;
          if (i_clr) m_drop = 16'd1;
          else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else if (i_clr) begin
          m_ovf  = 1'b0;
          m_drop = '0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cycle_count", 224'(o_count), 224'(m_q.size()));
      chk("cycle_flags", {o_rec_valid, o_full, o_almost_full, o_overflow},
          {m_q.size() > 0, m_q.size() == 32, m_q.size() >= 30, m_ovf});
      chk("cycle_drop", 224'(o_drop_count), 224'(m_drop));
      chk("cycle_head", {o_r7, o_r6, o_r5, o_r4, o_r3, o_r2, o_r1},
          (m_q.size() > 0) ? m_q[0] : 224'd0);
    end
  end

  task automatic set_regs(input logic [31:0] r1);
    i_r[0] = r1;
    for (int k = 1; k < 7; k++) i_r[k] = $urandom;
  endtask

  // Apply one cycle of controls, then return to idle 1ns after the edge.
  task automatic drive(input logic v, input logic p, input logic c);
    i_valid = v; i_pop = p; i_clr = c;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_pop = 1'b0; i_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_pop = 1'b0; i_clr = 1'b0;
    set_regs(32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_rec_valid, o_full, o_almost_full, o_overflow, o_count, o_drop_count, o_r1, o_r7}, '0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("pop_empty", {o_count, o_r1, o_r4, o_r7}, '0);

    // Single record 0x11..0x77.
    for (int k = 0; k < 7; k++) i_r[k] = 32'h11 * (k + 1);
    drive(1'b1, 1'b0, 1'b0);
    chk("single_valid", {o_rec_valid, o_count}, {1'b1, 6'd1});
    chk("single_words", {o_r1, o_r2, o_r3, o_r4, o_r5, o_r6, o_r7},
        {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77});
    drive(1'b0, 1'b1, 1'b0);
    chk("single_popped", {o_rec_valid, o_r1, o_r7}, '0);

    // Fill to 32 with index in word 1.
    for (int i = 0; i < 32; i++) begin
      set_regs(32'(i));
      drive(1'b1, 1'b0, 1'b0);
      chk("fill_almost_full", 224'(o_almost_full), 224'(i + 1 >= 30));
    end
    chk("fill_full", {o_full, o_count}, {1'b1, 6'd32});

    for (int i = 0; i < 3; i++) begin
      set_regs(32'hDEAD_0000 + 32'(i));
      drive(1'b1, 1'b0, 1'b0);
    end
    chk("drop_stats", {o_overflow, o_drop_count, o_r1}, {1'b1, 16'd3, 32'd0});
    drive(1'b0, 1'b0, 1'b1);
    chk("drop_cleared", {o_overflow, o_drop_count}, '0);

    // Full push+pop: slot reused, no drop.
    set_regs(32'd100);
    drive(1'b1, 1'b1, 1'b0);
    chk("full_pushpop", {o_count, o_drop_count, o_overflow}, {6'd32, 16'd0, 1'b0});
    for (int i = 0; i < 32; i++) begin
      chk("drain_order", 224'(o_r1), (i < 31) ? 224'(i + 1) : 224'd100);
      drive(1'b0, 1'b1, 1'b0);
    end
    chk("drained", {o_rec_valid, o_count}, '0);

    set_regs(32'd55);
    drive(1'b1, 1'b1, 1'b0);
    chk("empty_pushpop", {o_count, o_r1}, {6'd1, 32'd55});
    drive(1'b0, 1'b1, 1'b0);

    // Interleaved random traffic with an asynchronous reset mid-burst.
    for (int i = 0; i < 100; i++) begin
      set_regs($urandom);
      if (i == 50) begin
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {o_rec_valid, o_count, o_overflow, o_drop_count, o_r1}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_regs(32'hCAFE);
        drive(1'b1, 1'b0, 1'b0);
        chk("post_reset_push", {o_rec_valid, o_count, o_r1}, {1'b1, 6'd1, 32'hCAFE});
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      end
    end

    // Push-heavy traffic to hit full, drops and clears.
    for (int i = 0; i < 400; i++) begin
      set_regs($urandom);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/order_out_fifo.md
Name: order_out_fifo

Overview:
- Receive-side capture buffer for the strategy core's order output bus: seven REG_WIDTH order words plus a one-cycle valid strobe.
- On each strobe it latches one complete order record into a BUFFER_SIZE-deep first-word-fall-through FIFO.
- The host/driver side reads the head record and pops it with a strobe.
- Reports occupancy, overflow and drop statistics; o_almost_full feeds the core's i_book_is_busy input as back-pressure.

Parameters:
- REG_WIDTH, 32, width of each order word.
- BUFFER_SIZE, 32, FIFO depth in records; power of two, minimum 2.
- ALMOST_FULL, 30, occupancy at or above which o_almost_full asserts; range 1..BUFFER_SIZE.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset_n  input  1  reset; asynchronous, active-low.
- i_valid  input  1  order strobe from core; one record per high cycle.
- i_reg_1 .. i_reg_7  input  REG_WIDTH each  order words captured when i_valid=1.
- i_pop  input  1  host consumes head record this cycle.
- i_clear_overflow  input  1  clears o_overflow and o_drop_count.
- o_reg_1 .. o_reg_7  output  REG_WIDTH each  head record words.
- o_rec_valid  output  1  FIFO non-empty; o_reg_* hold a valid record.
- o_count  output  $clog2(BUFFER_SIZE)+1  records stored.
- o_full  output  1  o_count == BUFFER_SIZE.
- o_almost_full  output  1  o_count >= ALMOST_FULL.
- o_overflow  output  1  sticky: at least one record dropped.
- o_drop_count  output  DROP_CNT_WIDTH  records dropped, saturating.

Behaviour:
- Reset (async assert, sync release):
  - Write pointer, read pointer and o_count = 0.
  - o_rec_valid, o_full, o_almost_full, o_overflow = 0; o_drop_count = 0.
  - o_reg_* = 0. Storage contents are don't-care.
  - Reset mid-operation discards all stored records immediately.
- Storage: BUFFER_SIZE x (7*REG_WIDTH) flop array, write pointer, read pointer. Pointers wrap modulo BUFFER_SIZE.
- Push: i_valid=1 and (not full, or pop accepted same cycle).
  - All seven words written atomically at the write pointer; write pointer increments.
- Pop: i_pop=1 and o_rec_valid=1; read pointer increments. Pop while empty is ignored, with no state change.
- Latency:
  - A record pushed into an empty FIFO at edge N is on o_reg_* with o_rec_valid=1 right after edge N.
  - One-cycle strobe-to-visible. No combinational path from i_* to o_*.
- o_reg_* show storage at the read pointer when o_rec_valid=1, and are forced to 0 when empty.
- o_count, o_full, o_almost_full and o_rec_valid are registered (or decoded from registered state) and consistent in the same cycle.
- Simultaneous push+pop:
  - Non-empty, not full: both occur; o_count unchanged.
  - Full: pop frees the slot, push accepted, no drop; o_count stays BUFFER_SIZE.
  - Empty: pop ignored, push accepted; o_count = 1.
- Overflow: i_valid=1 while full with no accepted pop.
  - Record discarded; storage unchanged; o_overflow set; o_drop_count increments, saturating at all-ones.
- i_clear_overflow=1:
  - Next state is o_overflow=0, o_drop_count=0.
  - If a drop occurs in the same cycle, the drop wins: o_overflow=1, o_drop_count=1.
- Arithmetic:
  - Pointers are $clog2(BUFFER_SIZE) bits, natural wrap.
  - o_count is updated by +1 / -1 / 0 and never exceeds BUFFER_SIZE or underflows.

Test Plan:
- Reset then idle -> all outputs 0. Pop on empty -> o_count stays 0, o_reg_* stay 0.
- Single push (i_reg_1..7 = 0x11..0x77) -> one cycle later o_rec_valid=1, o_reg_1=0x11 .. o_reg_7=0x77, o_count=1. Pop -> o_rec_valid=0, o_reg_*=0.
- Push 32 records (i_reg_1 = index) -> o_full=1 and o_count=32; o_almost_full=1 from o_count=30 onward. Pop all -> i_reg_1 order 0..31, no loss.
- When full, push 3 more without pop -> o_drop_count=3, o_overflow=1, head still index 0. i_clear_overflow -> both 0.
- When full, push+pop in the same cycle -> o_count=32, o_drop_count=0, new record emerges after the 31 earlier ones. When empty, push+pop -> o_count=1.
- Wrap and reset: 100 interleaved push/pop cycles keep FIFO order across pointer wrap. Assert i_reset_n low mid-burst -> outputs 0 at once, first post-reset push appears correctly.
